// File: rtl/mips32_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to instruction memory and buffers
// the returned {ir, npc} pairs for decode, with branch redirect, halt and backpressure.
module mips32_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          halt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_ir,
    output logic [31:0]   out_npc
);

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LastPtr  = PW'(DEPTH - 1);
    localparam logic [CW:0]   DepthLvl = (CW + 1)'(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] req_addr_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          inflight_q;
    logic          discard_q, discard_d;

    logic [31:0]   ir_mem  [DEPTH];
    logic [31:0]   npc_mem [DEPTH];

    logic          pop;
    logic          push;
    logic [CW:0]   level;
    logic          unused_pc_hi;

    assign unused_pc_hi = ^redirect_pc[31:AW];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign out_valid = (count_q != '0);
    assign out_ir    = ir_mem[rd_ptr_q];
    assign out_npc   = npc_mem[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    // Redirect wins over the response landing this cycle; discard covers the one after.
    assign push      = inflight_q & ~discard_q & ~redirect;

    // Projected occupancy once the current response lands and the current pop leaves.
    assign level     = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign imem_req  = rst_n & ~halt & ~redirect & (level < DepthLvl);
    assign imem_addr = pc_q;

    always_comb begin
        pc_d      = pc_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        discard_d = 1'b0;
        if (redirect) begin
            pc_d      = redirect_pc[AW-1:0];
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            discard_d = inflight_q;
        end else begin
            if (imem_req) begin
                pc_d = pc_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            req_addr_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= imem_req;
            discard_q  <= discard_d;
            if (imem_req) begin
                req_addr_q <= pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr_q]  <= imem_rdata;
            npc_mem[wr_ptr_q] <= {{(32 - AW){1'b0}}, req_addr_q} + 32'd1;
        end
    end

endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; legal values 2..8.
REQ-002 Parameter AW, default 10, instruction-memory word-address width (1024 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory this cycle.
REQ-006 imem_addr  output  AW  word address of the request; valid when imem_req=1.
REQ-007 imem_rdata  input  32  instruction word, valid exactly one cycle after the matching imem_req.
REQ-008 redirect  input  1  taken-branch redirect from the EX/MEM side.
REQ-009 redirect_pc  input  32  branch target word address; only bits [AW-1:0] are used.
REQ-010 halt  input  1  level-sensitive; stops new requests.
REQ-011 out_valid  output  1  out_ir and out_npc hold a fetched instruction.
REQ-012 out_ready  input  1  decode stage accepts the entry this cycle.
REQ-013 out_ir  output  32  instruction word for the IF/ID register.
REQ-014 out_npc  output  32  address of out_ir, zero-extended, plus 1.

Function
REQ-015 The block SHALL hold an internal fetch PC of AW bits, a DEPTH-entry FIFO of {ir, npc}, an occupancy count and a single in-flight flag.
REQ-016 A transfer SHALL occur when out_valid=1 and out_ready=1 in the same cycle (pop).
REQ-017 The block SHALL assert imem_req when all three hold: halt=0; redirect=0; occupancy + inflight - pop < DEPTH.
REQ-018 When imem_req=1, imem_addr SHALL equal PC, and PC SHALL increment by 1 modulo 2^AW (1023 wraps to 0).
REQ-019 The inflight flag SHALL be set in the cycle after a request and cleared otherwise; at most one request is outstanding.
REQ-020 In a cycle where inflight=1 and no discard is pending, imem_rdata SHALL be pushed with npc = {zero-extended request address} + 1; at address 1023 npc = 1024.
REQ-021 Latency: a request in cycle N SHALL produce an entry with out_valid=1 in cycle N+2 if the FIFO was empty.
REQ-022 Throughput: with out_ready held at 1 and no halt or redirect, the block SHALL deliver one instruction per cycle after the initial 2-cycle fill.
REQ-023 Simultaneous push and pop SHALL be legal at any occupancy, including full; the occupancy count stays unchanged.
REQ-024 Full case: the block SHALL never push when occupancy = DEPTH and pop = 0; REQ-017 guarantees this.
REQ-025 Empty case: out_valid SHALL be 0, and out_ir and out_npc are don't-care.
REQ-026 While out_valid=1 and out_ready=0, out_ir and out_npc SHALL remain stable.
REQ-027 FIFO order SHALL be strict program order of requests.
REQ-028 Redirect SHALL have priority over pop, push and issue. On the redirect cycle:
- occupancy is cleared to 0;
- any in-flight response is marked for discard and is not pushed on the next cycle;
- PC is loaded with redirect_pc[AW-1:0];
- no request is issued.
REQ-029 After a redirect, out_valid SHALL be 0 in the following cycle, and the first request to the target SHALL be issued in that following cycle (if halt=0).
REQ-030 Back-to-back redirects SHALL each restart fetch; only the last target is fetched.
REQ-031 Halt behaviour: while halt=1, no new requests are issued; an in-flight response is still pushed, and the FIFO continues to drain. Deasserting halt resumes fetch at the current PC.
REQ-032 Redirect while halt=1 SHALL still flush and load PC, with fetch starting when halt falls.

Reset
REQ-033 While rst_n=0, the following SHALL all read 0: PC, occupancy, inflight, the discard flag, imem_req and out_valid.
REQ-034 Reset mid-operation SHALL abandon queued and in-flight data, and the response arriving after reset release SHALL be ignored.
REQ-035 The first request after rst_n rises SHALL be to address 0, in the first clock edge cycle with halt=0.

Verification
REQ-036 Stream: the memory holds word k = k, out_ready=1, with no halt or redirect -> out_ir = 0,1,2,... one per cycle from cycle 2; out_npc = out_ir+1.
REQ-037 Backpressure: out_ready=0 for 10 cycles -> exactly DEPTH=4 entries queue, imem_req drops, and out_ir=0 holds stable; out_ready=1 -> words 0..3 then 4 are delivered with no loss or duplication.
REQ-038 Redirect: redirect=1, redirect_pc=0x100 with 3 entries queued plus 1 in flight -> out_valid=0 the next cycle; the next request is to 0x100, and the next out_ir = 0x100 with out_npc = 0x101.
REQ-039 Wrap: redirect_pc=1022 -> outputs are 1022, 1023 then 0, with out_npc 1023, 1024 then 1.
REQ-040 Halt: halt=1 with 1 request in flight -> that word is still delivered, then out_valid=0 and imem_req=0; halt=0 -> fetch resumes at the next sequential address.
REQ-041 Async reset: drop rst_n with no clock edge while the queue is full -> out_valid and imem_req go to 0 immediately; after release, the first imem_addr = 0.
